// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps all input combinations, captures the response truth vector and checks it against an expected mask
module truth_table_capture #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 s,
   output logic [N_IN-1:0]      vars,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   tbl,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [N_IN-1:0]      first_err,
   output logic                 err_valid
);
   localparam logic [3:0] SET = 4'(SETTLE);
   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
   state_t state, nxt;
   logic [3:0] cnt;
   logic [2**N_IN-1:0] exp_l;
   logic mis, last;
   always_comb begin
      mis  = s !== exp_l[vars];
      last = vars == '1;
      nxt  = state;
      case (state)
         IDLE:    nxt = start ? (SETTLE == 0 ? SAMPLE : WAIT) : IDLE;
         WAIT:    nxt = cnt <= 4'd1 ? SAMPLE : WAIT;
         SAMPLE:  nxt = last ? DONE : (SETTLE == 0 ? SAMPLE : WAIT);
         default: nxt = IDLE;
      endcase
      busy = state == WAIT || state == SAMPLE;
      done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         vars      <= '0;
         tbl       <= '0;
         pass      <= 1'b0;
         err_count <= '0;
         first_err <= '0;
         err_valid <= 1'b0;
         cnt       <= '0;
         exp_l     <= '0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (start) begin
               exp_l     <= expected;
               tbl       <= '0;
               err_count <= '0;
               first_err <= '0;
               err_valid <= 1'b0;
               pass      <= 1'b0;
               vars      <= '0;
               cnt       <= SET;
            end
            WAIT: cnt <= cnt - 4'd1;
            SAMPLE: begin
               tbl[vars] <= s;
               if (mis) begin
                  err_count <= err_count + 1'b1;
                  if (!err_valid) begin
                     first_err <= vars;
                     err_valid <= 1'b1;
                  end
               end
               // pass folds in the final sample so it is valid alongside done
               if (last) pass <= err_count == '0 && !mis;
               else begin
                  vars <= vars + 1'b1;
                  cnt  <= SET;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Sequential truth-table reader. It sweeps every input combination of a combinational function under test and samples the function's response to each one.
- It assembles the full truth vector, compares it against an expected minterm mask, and reports pass/fail with error count and first failing index.
- It is the capture/check end of the stimulus/monitor flow used for the team's expression exercises. It replaces manual inspection of the per-combination monitor output with a self-checking result.

Parameters:
- N_IN, 3, number of function inputs (legal 1..4); vars[N_IN-1] is the leftmost variable (x), vars[0] the rightmost (z).
- SETTLE, 1, idle cycles between driving a combination and sampling s (legal 0..15).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; accepted only in IDLE.
- expected  input  2**N_IN  expected truth vector; bit i = required s for vars==i; latched on accepted start.
- s  input  1  response of function under test.
- vars  output  N_IN  current input combination driven to the function.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse when the sweep completes.
- table  output  2**N_IN  captured truth vector; bit i = s sampled for vars==i.
- pass  output  1  1 when table matches the latched expected on all bits; valid from done, held.
- err_count  output  N_IN+1  number of mismatching combinations.
- first_err  output  N_IN  lowest mismatching index; 0 when none.
- err_valid  output  1  1 if at least one mismatch was found (equals ~pass after done).

Behaviour:
- Reset (synchronous, active-high) forces the following, overriding any in-progress sweep, with no done pulse:
  - state=IDLE; vars=0; busy=0; done=0; table=0; pass=0; err_count=0; first_err=0; err_valid=0; settle counter=0; expected latch=0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - On start=1, at that edge: latch expected; clear table, err_count, first_err, err_valid, pass; vars=0; counter=SETTLE; go to WAIT (SAMPLE if SETTLE==0).
- WAIT:
  - Counter decrements each cycle; vars is held.
  - When counter reaches 1, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - At the edge, table[vars]<=s.
  - A mismatch is s !== expected_l[vars]; an X/Z on s counts as a mismatch and is captured as-is.
  - On mismatch: err_count++. If err_valid==0, set first_err<=vars and err_valid<=1.
  - If vars==2**N_IN-1, go to DONE. Otherwise vars<=vars+1, reload counter=SETTLE, return to WAIT (or stay in SAMPLE if SETTLE==0).
- DONE (one cycle):
  - done=1, busy=0.
  - pass=1 iff err_count==0 including the final sample; pass is computed combinationally into the DONE-entry edge, so it is valid in the same cycle done=1.
  - Return to IDLE. Results and vars hold until the next accepted start or reset.
- Timing: each combination occupies SETTLE+1 cycles, so done asserts 2**N_IN*(SETTLE+1) cycles after the start edge.
  - N_IN=3, SETTLE=1: done in cycle 16.
  - N_IN=3, SETTLE=0: done in cycle 8.
- busy is 1 in WAIT/SAMPLE, 0 in IDLE/DONE.
- start while busy or in the DONE cycle is ignored; there is no queued restart. start held high through IDLE restarts the sweep on the first IDLE cycle after DONE.
- expected changing during a sweep has no effect (latched copy used).
- No wrap-around: vars stops at 2**N_IN-1 and is not incremented past it.
- err_count width N_IN+1 holds the maximum 2**N_IN without overflow.

Test Plan:
- N_IN=3, SETTLE=1, bench models s=(x|~y)&(~y|~z) from vars, expected=8'h73, pulse start -> vars walks 0..7 holding 2 cycles each; done pulses at cycle 16; table=8'h73, pass=1, err_count=0, err_valid=0, first_err=0.
- Same function, expected=8'h72 -> table=8'h73, pass=0, err_count=1, first_err=0, err_valid=1.
- Same function, expected=8'h00 -> err_count=5, first_err=0, pass=0; then expected=8'hFF on rerun -> err_count=3, first_err=2.
- SETTLE=0, s tied to vars[2] (x), expected=8'hF0 -> done at cycle 8, table=8'hF0, pass=1; start pulsed at cycle 4 is ignored, with no restart and sweep unchanged.
- Reset asserted while vars==5 mid-sweep -> next edge: all outputs 0, state IDLE, no done pulse; a new start then yields a full correct sweep.
- s driven 1'bx for vars==6 only, otherwise the correct function, expected=8'h73 -> err_count=1, first_err=6, table[6]=x, pass=0.
